// File: rtl/l1_mesi_cache_ctrl_pkg.sv
// l1_mesi_cache_ctrl_pkg: address, MESI, controller FSM and cache-line types
package l1_mesi_cache_ctrl_pkg;
    localparam int ADDR_W = 25;
    typedef logic [ADDR_W-1:0] Taddress;
    typedef enum logic [1:0] {MOD, EXC, SHR, INV} Tmesi_state;
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP, SNP_WB} Tcache_fsm;
    typedef struct packed {
        Taddress     tag;
        logic [31:0] data;
        Tmesi_state  state;
    } Tcache_line;
endpackage

// File: rtl/l1_mesi_cache_ctrl_line_array.sv
// l1_line_array: per-line tag/data/MESI register file, line states reset to INV
module l1_line_array
    import l1_mesi_cache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int IDX_W = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] raddr,
    output Tcache_line       rline,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  Tcache_line       wline
);
    Taddress     tags   [NUM_LINES];
    logic [31:0] datas  [NUM_LINES];
    Tmesi_state  states [NUM_LINES];
    assign rline = '{tag: tags[raddr], data: datas[raddr], state: states[raddr]};
    always_ff @(posedge clk) begin
        if (reset && we) begin
            tags[waddr] <= wline.tag;
            datas[waddr] <= wline.data;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) states[i] <= INV;
        end else if (we) begin
            states[waddr] <= wline.state;
        end
    end
endmodule

// File: rtl/l1_mesi_cache_ctrl.sv
// l1_mesi_cache_ctrl: direct-mapped write-back write-allocate MESI L1 data cache controller
module l1_mesi_cache_ctrl
    import l1_mesi_cache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  Taddress     cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        snp_valid,
    input  logic        snp_inv,
    input  Taddress     snp_addr,
    output logic        snp_done,
    output logic        snp_hit,
    output logic        bus_upgr,
    input  logic        mem_shared,
    output Taddress     mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output Tmesi_state  mem_mesi,
    input  logic [31:0] mem_rdata
);
    localparam int IDX_W = $clog2(NUM_LINES);
    Tcache_fsm   state, state_nx;
    Taddress     cur_addr, look_addr, victim_addr;
    logic        cur_we, cur_inv, hit, last, wen;
    logic [31:0] cur_wdata;
    logic [3:0]  cnt;
    Tcache_line  rline, wline;
    function automatic Taddress tag_of(input Taddress a);
        return a >> IDX_W;
    endfunction
    // In IDLE the only lookup that can happen is a snoop; otherwise the latched request owns the port.
    assign look_addr = (state == IDLE) ? snp_addr : cur_addr;
    assign hit = rline.state != INV && rline.tag == tag_of(look_addr);
    assign last = cnt == 4'(MEM_LAT - 1);
    assign victim_addr = (rline.tag << IDX_W) | Taddress'(look_addr[IDX_W-1:0]);
    l1_line_array #(.NUM_LINES(NUM_LINES)) u_lines (
        .clk(clk),
        .reset(reset),
        .raddr(look_addr[IDX_W-1:0]),
        .rline(rline),
        .we(wen),
        .waddr(look_addr[IDX_W-1:0]),
        .wline(wline)
    );
    assign cpu_ready = reset && state == IDLE && !snp_valid;
    assign cpu_rvalid = state == RESP;
    assign cpu_rdata = (state == RESP) ? rline.data : '0;
    assign bus_upgr = state == LOOKUP && hit && cur_we && rline.state == SHR;
    assign mem_we = state == WB || state == SNP_WB;
    assign mem_addr = mem_we ? victim_addr : (state == FILL) ? cur_addr : '0;
    assign mem_wdata = mem_we ? rline.data : '0;
    assign mem_mesi = (state == WB) ? MOD : (state == SNP_WB && !cur_inv) ? SHR : INV;
    always_comb begin
        state_nx = state;
        wen = 1'b0;
        wline = rline;
        case (state)
            IDLE: begin
                if (snp_valid) begin
                    if (hit && rline.state == MOD) begin
                        state_nx = SNP_WB;
                    end else if (hit) begin
                        wen = 1'b1;
                        wline.state = snp_inv ? INV : SHR;
                    end
                end else if (cpu_req) begin
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nx = hit ? RESP : (rline.state == MOD) ? WB : FILL;
                if (hit && cur_we) begin
                    wen = 1'b1;
                    wline.data = cur_wdata;
                    wline.state = MOD;
                end
            end
            WB: state_nx = FILL;
            FILL: begin
                if (last) begin
                    state_nx = RESP;
                    wen = 1'b1;
                    wline = '{tag: tag_of(cur_addr), data: cur_we ? cur_wdata : mem_rdata,
                              state: cur_we ? MOD : mem_shared ? SHR : EXC};
                end
            end
            RESP: state_nx = IDLE;
            SNP_WB: begin
                state_nx = IDLE;
                wen = 1'b1;
                wline.state = cur_inv ? INV : SHR;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            cur_addr <= '0;
            cur_we <= 1'b0;
            cur_inv <= 1'b0;
            cur_wdata <= '0;
            snp_done <= 1'b0;
            snp_hit <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= (state == FILL) ? cnt + 4'd1 : '0;
            snp_done <= (state == IDLE && snp_valid && !(hit && rline.state == MOD)) || state == SNP_WB;
            snp_hit <= (state == IDLE && snp_valid && hit) || state == SNP_WB;
            if (state == IDLE && snp_valid) begin
                cur_addr <= snp_addr;
                cur_inv <= snp_inv;
            end else if (state == IDLE && cpu_req) begin
                cur_addr <= cpu_addr;
                cur_we <= cpu_we;
                cur_wdata <= cpu_wdata;
            end
        end
    end
endmodule

// File: tb/tb_l1_mesi_cache_ctrl.sv
// tb_l1_mesi_cache_ctrl: directed + randomized bench against a line-level MESI reference model
module tb_l1_mesi_cache_ctrl;
    import l1_mesi_cache_ctrl_pkg::*;
    localparam int L = 2;
    logic        clk = 1'b0, reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, snp_valid = 1'b0, snp_inv = 1'b0, mem_shared = 1'b0;
    Taddress     cpu_addr = '0, snp_addr = '0;
    logic [31:0] cpu_wdata = '0, mem_rdata = '0;
    logic        cpu_ready, cpu_rvalid, snp_done, snp_hit, bus_upgr, mem_we;
    logic [31:0] cpu_rdata, mem_wdata;
    Taddress     mem_addr;
    Tmesi_state  mem_mesi;
    int checks = 0, errors = 0, upg = 0;
    typedef struct {Taddress a; logic [31:0] d; Tmesi_state m;} wr_t;
    wr_t wq[$];
    logic [31:0] mem [Taddress];
    logic [31:0] gold [Taddress];
    typedef enum {T_I, T_S, T_E, T_M} mst_t;
    mst_t        m_st [64];
    Taddress     m_a [64];
    logic [31:0] m_d [64];
    logic        es_hit, es_wb;
    int          es_lat;
    Taddress     es_wa;
    logic [31:0] es_wd;
    Tmesi_state  es_m;

    always #5 clk = ~clk;

    l1_mesi_cache_ctrl #(.NUM_LINES(64), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .snp_valid(snp_valid), .snp_inv(snp_inv), .snp_addr(snp_addr),
        .snp_done(snp_done), .snp_hit(snp_hit), .bus_upgr(bus_upgr),
        .mem_shared(mem_shared), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_mesi(mem_mesi), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(input Taddress a);
        return {7'h0, a} ^ 32'hA5C3_0F00;
    endfunction
    function automatic logic [31:0] mem_val(input Taddress a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] gold_val(input Taddress a);
        return gold.exists(a) ? gold[a] : init_val(a);
    endfunction
    function automatic Taddress rnd_addr();
        int x = $urandom_range(0, 4);
        return {16'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), 6'(x == 4 ? 5 : x)};
    endfunction

    // Main memory: writes land and read data is presented on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wq.push_back('{mem_addr, mem_wdata, mem_mesi});
        end
        if (bus_upgr) upg++;
        mem_rdata = mem_val(mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_snp_done", snp_done, 0);
        chk("rst_snp_hit", snp_hit, 0);
        chk("rst_bus_upgr", bus_upgr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_mesi", mem_mesi, INV);
    endtask

    task automatic snp_model(input logic inv, input Taddress a);
        int i = int'(a[5:0]);
        es_hit = m_st[i] != T_I && m_a[i] == a;
        es_wb = es_hit && m_st[i] == T_M;
        es_lat = es_wb ? 2 : 1;
        es_wa = m_a[i];
        es_wd = m_d[i];
        es_m = inv ? INV : SHR;
        if (es_hit) m_st[i] = inv ? T_I : T_S;
    endtask

    task automatic snp_wait();
        int lat = 1;
        while (!snp_done && lat < 20) begin @(negedge clk); lat++; end
        chk("snp_lat", lat, es_lat);
        chk("snp_hit", snp_hit, es_hit);
        chk("snp_wb_cnt", wq.size(), es_wb);
        if (es_wb && wq.size() > 0) begin
            chk("snp_wb_addr", wq[0].a, es_wa);
            chk("snp_wb_data", wq[0].d, es_wd);
            chk("snp_wb_mesi", wq[0].m, es_m);
        end
        wq.delete();
    endtask

    task automatic snoop(input logic inv, input Taddress a);
        snp_model(inv, a);
        @(negedge clk);
        snp_valid = 1'b1; snp_inv = inv; snp_addr = a;
        @(negedge clk);
        snp_valid = 1'b0;
        snp_wait();
    endtask

    task automatic cpu_op(input logic we, input Taddress a, input logic [31:0] d, input logic sh,
                          input bit tie = 0, input logic sinv = 0, input Taddress sa = '0);
        int i = int'(a[5:0]);
        int lat = 0, n = 0, u0, exp_lat;
        logic hit, exp_wb, exp_upg;
        Taddress wa;
        logic [31:0] wd, exp_d;
        if (tie) snp_model(sinv, sa);
        hit = m_st[i] != T_I && m_a[i] == a;
        exp_wb = !hit && m_st[i] == T_M;
        wa = m_a[i];
        wd = m_d[i];
        exp_lat = hit ? 2 : exp_wb ? 3 + L : 2 + L;
        exp_upg = hit && we && m_st[i] == T_S;
        exp_d = we ? d : gold_val(a);
        if (we) gold[a] = d;
        m_st[i] = we ? T_M : hit ? m_st[i] : sh ? T_S : T_E;
        m_a[i] = a;
        m_d[i] = exp_d;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; mem_shared = sh;
        if (tie) begin
            snp_valid = 1'b1; snp_inv = sinv; snp_addr = sa;
            #1 chk("tie_cpu_ready", cpu_ready, 0);
            @(negedge clk);
            snp_valid = 1'b0;
            snp_wait();
        end
        #1;
        while (!cpu_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("cpu_accept", n < 50, 1);
        u0 = upg;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) cpu_req = 1'b0;
        end while (!cpu_rvalid && lat < 40);
        chk("cpu_lat", lat, exp_lat);
        if (!we) chk("cpu_rdata", cpu_rdata, exp_d);
        chk("bus_upgr_cnt", upg - u0, exp_upg);
        chk("wb_cnt", wq.size(), exp_wb);
        if (exp_wb && wq.size() > 0) begin
            chk("wb_addr", wq[0].a, wa);
            chk("wb_data", wq[0].d, wd);
            chk("wb_mesi", wq[0].m, MOD);
        end
        wq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Taddress a1 = {16'h0000, 9'h005};
        Taddress a2 = {16'h1234, 9'h005};
        Taddress ra = {16'hBEEF, 9'h01F};
        Taddress live[$];
        for (int i = 0; i < 64; i++) begin m_st[i] = T_I; m_a[i] = '0; m_d[i] = '0; end
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b1;
        cpu_op(0, a1, 32'h0, 0);
        cpu_op(0, a1, 32'h0, 0);
        cpu_op(1, a2, 32'hDEADBEEF, 0);
        cpu_op(0, a1, 32'h0, 0);
        cpu_op(1, a1, 32'h0BADF00D, 0);
        snoop(0, a1);
        cpu_op(1, a1, 32'h1234_5678, 0);
        cpu_op(0, a2, 32'h0, 0);
        cpu_op(0, a1, 32'h0, 0, 1, 0, a2);
        // Abort a fill with reset; the line must come back invalid and memory untouched.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ra; mem_shared = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("fill_mem_addr", mem_addr, ra);
        chk("fill_mem_we", mem_we, 0);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        chk("rst_no_mem_write", wq.size(), 0);
        wq.delete();
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (m_st[i] != T_I) live.push_back(m_a[i]);
            if (m_st[i] == T_M) gold[m_a[i]] = mem_val(m_a[i]);
            m_st[i] = T_I;
        end
        foreach (live[k]) snoop(0, live[k]);
        cpu_op(0, ra, 32'h0, 0);
        for (int k = 0; k < 200; k++) begin
            int sel = $urandom_range(0, 9);
            if (sel < 6) cpu_op(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'($urandom_range(0, 1)));
            else if (sel < 9) snoop(1'($urandom_range(0, 1)), rnd_addr());
            else cpu_op(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'($urandom_range(0, 1)),
                        1, 1'($urandom_range(0, 1)), rnd_addr());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
